// File: rtl/pio_poll_ctrl.sv
// Periodic PIO input poller: reads a PIO data register over an Avalon-style master,
// queues {old,new} change events in a FIFO and exposes them through a small register slave.
module pio_poll_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  m_address,
    output logic        m_read,
    input  logic [31:0] m_readdata,
    input  logic        m_waitrequest,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_EVENT  = 2'd3;

    // state   | meaning
    // IDLE    | polling disabled, baseline invalid
    // WAIT    | timer counting down to the next poll
    // READ    | m_read held until the slave drops waitrequest
    // CMP     | compare sample with baseline, push change event
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_CMP
    } state_t;

    state_t            state;
    logic [15:0]       timer;
    logic [15:0]       reload;
    logic [DATA_W-1:0] baseline;
    logic [DATA_W-1:0] sample;
    logic              baseline_valid;
    logic              discard;

    logic              ctrl_enable;
    logic              ctrl_irq_en;
    logic [15:0]       period;
    logic              overflow;
    logic [31:0]       rd_mux;

    logic [15:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [3:0]        count4;
    logic              not_empty;
    logic              full;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              ovf_set;
    logic [15:0]       entry;

    logic              unused_bits;

    assign m_address   = 2'd0;
    assign unused_bits = ^{m_readdata[31:DATA_W], s_writedata[31:16]};

    // A zero period still needs one WAIT cycle so the poll interval never collapses.
    assign reload = (period == 16'd0) ? 16'd1 : period;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            m_read         <= 1'b0;
            timer          <= '0;
            baseline       <= '0;
            sample         <= '0;
            baseline_valid <= 1'b0;
            discard        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baseline_valid <= 1'b0;
                    discard        <= 1'b0;
                    if (ctrl_enable) begin
                        timer <= reload;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!ctrl_enable) begin
                        baseline_valid <= 1'b0;
                        state          <= ST_IDLE;
                    end else if (timer <= 16'd1) begin
                        timer   <= '0;
                        m_read  <= 1'b1;
                        discard <= 1'b0;
                        state   <= ST_READ;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end
                ST_READ: begin
                    // A bus transaction must finish even if polling is switched off mid-way.
                    if (!ctrl_enable) begin
                        discard <= 1'b1;
                    end
                    if (!m_waitrequest) begin
                        m_read <= 1'b0;
                        if (discard || !ctrl_enable) begin
                            baseline_valid <= 1'b0;
                            state          <= ST_IDLE;
                        end else begin
                            sample <= m_readdata[DATA_W-1:0];
                            state  <= ST_CMP;
                        end
                    end
                end
                ST_CMP: begin
                    if (!ctrl_enable) begin
                        baseline_valid <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        if (!baseline_valid) begin
                            baseline       <= sample;
                            baseline_valid <= 1'b1;
                        end else if (sample != baseline) begin
                            baseline <= sample;
                        end
                        timer <= reload;
                        state <= ST_WAIT;
                    end
                end
                default: begin
                    m_read <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign push_req  = (state == ST_CMP) && ctrl_enable && baseline_valid && (sample != baseline);
    assign entry     = {8'(baseline), 8'(sample)};
    assign not_empty = (count != '0);
    assign full      = (count == CNT_FULL);
    assign pop       = s_read && (s_address == A_EVENT) && not_empty;
    // Simultaneous pop frees the slot being pushed into, so a full FIFO still accepts.
    assign push_ok   = push_req && (!full || pop);
    assign ovf_set   = push_req && full && !pop;
    assign count4    = 4'(count);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (s_address)
            A_CTRL:   rd_mux = {30'd0, ctrl_irq_en, ctrl_enable};
            A_PERIOD: rd_mux = {16'd0, period};
            A_STATUS: rd_mux = {24'd0, count4, 2'b00, overflow, not_empty};
            A_EVENT:  rd_mux = not_empty ? {16'd0, mem[rd_ptr]} : 32'd0;
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_enable <= 1'b0;
            ctrl_irq_en <= 1'b0;
            period      <= '0;
            overflow    <= 1'b0;
            s_readdata  <= '0;
            irq         <= 1'b0;
        end else begin
            if (s_write) begin
                case (s_address)
                    A_CTRL: begin
                        ctrl_enable <= s_writedata[0];
                        ctrl_irq_en <= s_writedata[1];
                    end
                    A_PERIOD: period <= s_writedata[15:0];
                    default: ;
                endcase
            end
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (s_write && (s_address == A_STATUS)) begin
                overflow <= 1'b0;
            end
            if (s_read) begin
                s_readdata <= rd_mux;
            end
            irq <= ctrl_irq_en && not_empty;
        end
    end

endmodule

// File: tb/tb_pio_poll_ctrl.sv
// Directed bench for pio_poll_ctrl: polling cadence, change events, wait states,
// FIFO overflow and full push/pop, enable-off during a read and reset mid-read.
module tb_pio_poll_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;

    logic [7:0]  pio;
    int          ws_n;
    int          ws_cnt = 0;

    int n_checks = 0;
    int n_pass   = 0;

    int   cyc = 0;
    int   last_rise = 0;
    int   last_fall = 0;
    int   last_interval = 0;
    int   hi_len = 0;
    int   last_len = 0;
    int   n_rises = 0;
    int   irq_lat = 0;
    logic prev_read = 1'b0;
    logic prev_irq = 1'b0;

    always #5 clk = ~clk;

    pio_poll_ctrl #(.DATA_W(8), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .m_address     (m_address),
        .m_read        (m_read),
        .m_readdata    (m_readdata),
        .m_waitrequest (m_waitrequest),
        .s_address     (s_address),
        .s_read        (s_read),
        .s_write       (s_write),
        .s_writedata   (s_writedata),
        .s_readdata    (s_readdata),
        .irq           (irq)
    );

    // PIO slave: ws_n wait cycles per read, garbage on the bus while waiting.
    assign m_waitrequest = m_read && (ws_cnt < ws_n);
    assign m_readdata    = m_waitrequest ? 32'hC0FF_EEFF : {24'hC0FFEE, pio};

    always @(posedge clk) begin
        if (!m_read) ws_cnt <= 0;
        else if (m_waitrequest) ws_cnt <= ws_cnt + 1;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (m_read && !prev_read) begin
            if (n_rises > 0) last_interval = cyc - last_rise;
            last_rise = cyc;
            n_rises   = n_rises + 1;
            hi_len    = 0;
        end
        if (m_read) hi_len = hi_len + 1;
        if (!m_read && prev_read) begin
            last_len  = hi_len;
            last_fall = cyc;
        end
        if (irq && !prev_irq) irq_lat = cyc - last_fall;
        prev_read = m_read;
        prev_irq  = irq;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        tick();
        s_write     = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        s_read    = 1'b1;
        tick();
        s_read    = 1'b0;
        d         = s_readdata;
    endtask

    task automatic wait_poll(input string tag);
        int  i;
        bit  ok;
        ok = 1'b1;
        i  = 0;
        while (!m_read && i < 100) begin tick(); i++; end
        if (!m_read) ok = 1'b0;
        i = 0;
        while (m_read && i < 200) begin tick(); i++; end
        if (m_read) ok = 1'b0;
        tick();
        n_checks++;
        if (!ok) $display("FAIL %s poll_timeout: m_read=%b, required a completed poll", tag, m_read);
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; s_read = 1'b0; s_write = 1'b0; s_address = 2'd0; s_writedata = '0;
        pio = 8'h5A; ws_n = 0;
        repeat (3) tick();
        reset = 1'b0;
        n_checks++; if (m_read !== 1'b0) $display("FAIL reset_m_read: got %b want 0", m_read); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else n_pass++;
        n_checks++; if (s_readdata !== 32'h0) $display("FAIL reset_readdata: got %h want 0", s_readdata); else n_pass++;
        n_checks++; if (m_address !== 2'd0) $display("FAIL reset_m_address: got %h want 0", m_address); else n_pass++;
        rd_reg(2'd0, d);
        n_checks++; if (d !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", d); else n_pass++;
        rd_reg(2'd1, d);
        n_checks++; if (d !== 32'h0) $display("FAIL reset_period: got %h want 0", d); else n_pass++;
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h0) $display("FAIL reset_status: got %h want 0", d); else n_pass++;
        rd_reg(2'd3, d);
        n_checks++; if (d !== 32'h0) $display("FAIL empty_event_read: got %h want 0", d); else n_pass++;
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h0) $display("FAIL status_after_empty_pop: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_periodic();
        logic [31:0] d;
        int n0;
        wr_reg(2'd1, 32'd3);
        n0 = n_rises;
        wr_reg(2'd0, 32'h1);
        repeat (30) tick();
        n_checks++; if (last_interval != 5) $display("FAIL poll_interval_p3: got %0d want 5", last_interval); else n_pass++;
        n_checks++; if (last_len != 1) $display("FAIL read_pulse_len: got %0d want 1", last_len); else n_pass++;
        n_checks++; if (n_rises - n0 != 6) $display("FAIL poll_count_p3: got %0d want 6", n_rises - n0); else n_pass++;
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h0) $display("FAIL const_input_status: got %h want 0", d); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL const_input_irq: got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_change_event();
        logic [31:0] d;
        int i;
        wr_reg(2'd0, 32'h3);
        pio = 8'hA5;
        i = 0;
        while (!irq && i < 40) begin tick(); i++; end
        n_checks++; if (irq !== 1'b1) $display("FAIL change_irq: got %b want 1", irq); else n_pass++;
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h11) $display("FAIL change_status: got %h want 00000011", d); else n_pass++;
        n_checks++; if (irq_lat != 2) $display("FAIL irq_latency: got %0d want 2", irq_lat); else n_pass++;
        rd_reg(2'd3, d);
        n_checks++; if (d !== 32'h5AA5) $display("FAIL change_event: got %h want 00005aa5", d); else n_pass++;
        tick();
        n_checks++; if (irq !== 1'b0) $display("FAIL irq_after_pop: got %b want 0", irq); else n_pass++;
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h0) $display("FAIL status_after_pop: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_waitstate();
        logic [31:0] d;
        int i;
        ws_n = 3;
        pio  = 8'h3C;
        i = 0;
        while (!irq && i < 60) begin tick(); i++; end
        n_checks++; if (irq !== 1'b1) $display("FAIL ws_irq: got %b want 1", irq); else n_pass++;
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h11) $display("FAIL ws_status: got %h want 00000011", d); else n_pass++;
        n_checks++; if (last_len != 4) $display("FAIL ws_pulse_len: got %0d want 4", last_len); else n_pass++;
        rd_reg(2'd3, d);
        n_checks++; if (d !== 32'hA53C) $display("FAIL ws_event: got %h want 0000a53c", d); else n_pass++;
        ws_n = 0;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0]  vals [5];
        logic [31:0] exp_ev [4];
        vals   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_ev = '{32'h3C11, 32'h1122, 32'h2233, 32'h3344};
        wait_poll("ovf_sync");
        for (int k = 0; k < 5; k++) begin
            pio = vals[k];
            wait_poll("ovf_fill");
        end
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h43) $display("FAIL ovf_status: got %h want 00000043", d); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            rd_reg(2'd3, d);
            n_checks++; if (d !== exp_ev[k]) $display("FAIL ovf_event%0d: got %h want %h", k, d, exp_ev[k]); else n_pass++;
        end
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h02) $display("FAIL ovf_sticky: got %h want 00000002", d); else n_pass++;
        wr_reg(2'd2, 32'h0);
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h0) $display("FAIL ovf_clear: got %h want 0", d); else n_pass++;
        n_checks++; if (irq !== 1'b0) $display("FAIL ovf_irq_drained: got %b want 0", irq); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  vals [4];
        logic [31:0] exp_ev [4];
        int i;
        vals   = '{8'h66, 8'h77, 8'h88, 8'h99};
        exp_ev = '{32'h6677, 32'h7788, 32'h8899, 32'h99AA};
        wait_poll("full_sync");
        for (int k = 0; k < 4; k++) begin
            pio = vals[k];
            wait_poll("full_fill");
        end
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h41) $display("FAIL full_status: got %h want 00000041", d); else n_pass++;
        pio = 8'hAA;
        i = 0;
        while (!m_read && i < 50) begin tick(); i++; end
        while (m_read && i < 100) begin tick(); i++; end
        n_checks++; if (m_read !== 1'b0 || i >= 100) $display("FAIL full_poll_timeout: m_read=%b i=%0d, required poll end", m_read, i); else n_pass++;
        rd_reg(2'd3, d);
        n_checks++; if (d !== 32'h5566) $display("FAIL pushpop_event: got %h want 00005566", d); else n_pass++;
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h41) $display("FAIL pushpop_status: got %h want 00000041", d); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            rd_reg(2'd3, d);
            n_checks++; if (d !== exp_ev[k]) $display("FAIL pushpop_drain%0d: got %h want %h", k, d, exp_ev[k]); else n_pass++;
        end
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h0) $display("FAIL pushpop_empty: got %h want 0", d); else n_pass++;
    endtask

    task automatic test_enable_clear();
        logic [31:0] d;
        int i;
        int n0;
        ws_n = 5;
        pio  = 8'hBB;
        i = 0;
        while (!m_read && i < 50) begin tick(); i++; end
        wr_reg(2'd0, 32'h0);
        i = 0;
        while (m_read && i < 50) begin tick(); i++; end
        rd_reg(2'd2, d);
        n_checks++; if (last_len != 6) $display("FAIL disable_read_len: got %0d want 6", last_len); else n_pass++;
        n_checks++; if (d !== 32'h0) $display("FAIL disable_discard: got %h want 0", d); else n_pass++;
        n0 = n_rises;
        repeat (20) tick();
        n_checks++; if (n_rises != n0) $display("FAIL disable_idle: got %0d polls want 0", n_rises - n0); else n_pass++;
        ws_n = 0;
    endtask

    task automatic test_reset_mid_read();
        logic [31:0] d;
        int i;
        wr_reg(2'd0, 32'h3);
        wait_poll("rst_baseline");
        pio = 8'hCC;
        wait_poll("rst_event");
        tick();
        n_checks++; if (irq !== 1'b1) $display("FAIL pre_reset_irq: got %b want 1", irq); else n_pass++;
        ws_n = 100;
        i = 0;
        while (!m_read && i < 50) begin tick(); i++; end
        tick();
        n_checks++; if (m_read !== 1'b1) $display("FAIL read_held: got %b want 1", m_read); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (m_read !== 1'b0) $display("FAIL reset_drops_read: got %b want 0", m_read); else n_pass++;
        reset = 1'b0;
        n_checks++; if (irq !== 1'b0) $display("FAIL rst_irq: got %b want 0", irq); else n_pass++;
        n_checks++; if (s_readdata !== 32'h0) $display("FAIL rst_readdata: got %h want 0", s_readdata); else n_pass++;
        rd_reg(2'd0, d);
        n_checks++; if (d !== 32'h0) $display("FAIL rst_ctrl: got %h want 0", d); else n_pass++;
        rd_reg(2'd2, d);
        n_checks++; if (d !== 32'h0) $display("FAIL rst_status: got %h want 0", d); else n_pass++;
        ws_n = 0;
        tick();
    endtask

    task automatic test_period_zero();
        int n0;
        n0 = n_rises;
        wr_reg(2'd0, 32'h1);
        repeat (21) tick();
        n_checks++; if (last_interval != 3) $display("FAIL period0_interval: got %0d want 3", last_interval); else n_pass++;
        n_checks++; if (n_rises - n0 != 7) $display("FAIL period0_count: got %0d want 7", n_rises - n0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_change_event();
        test_waitstate();
        test_overflow();
        test_back_to_back();
        test_enable_clear();
        test_reset_mid_read();
        test_period_zero();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/pio_poll_ctrl.md
PIO_POLL_CTRL -- requirements
Module: pio_poll_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of sampled PIO input field.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries, power of two.
REQ-003 SHALL have ports: clk input 1, sole clock; all logic on rising edge.
REQ-004 SHALL have ports: reset input 1, synchronous, active-high.
REQ-005 SHALL have master ports: m_address output 2, always 0 (PIO data register); m_read output 1; m_readdata input 32; m_waitrequest input 1.
REQ-006 SHALL have slave ports: s_address input 2; s_read input 1; s_write input 1; s_writedata input 32; s_readdata output 32; irq output 1.

Function
REQ-007 SHALL decode slave registers: 0 CTRL (bit0 enable, bit1 irq_en, R/W); 1 PERIOD (bits15:0, R/W); 2 STATUS (bit0 not_empty, bit1 overflow, bits[7:4] count, RO; any write clears overflow); 3 EVENT (RO, read pops).
REQ-008 SHALL return s_readdata registered, one cycle after s_read; unused bits zero.
REQ-009 SHALL run FSM states IDLE, WAIT, READ, CMP.
REQ-010 IDLE: while enable=0, stay; enable=1 -> load timer with PERIOD, go WAIT.
REQ-011 WAIT: decrement timer each cycle; at timer==0 go READ; PERIOD==0 treated as 1.
REQ-012 READ: assert m_read, held until m_waitrequest=0; capture m_readdata[DATA_W-1:0] that cycle, deassert m_read next cycle, go CMP.
REQ-013 CMP (one cycle): if baseline_valid=0, store sample as baseline, set baseline_valid, no event; else if sample != baseline, push {old baseline in [15:8], new sample in [7:0]} and update baseline; reload timer, go WAIT.
REQ-014 Poll-to-poll interval with m_waitrequest=0 SHALL be exactly PERIOD+2 cycles.
REQ-015 enable cleared in WAIT or CMP -> IDLE next cycle; cleared in READ -> complete transaction, discard data, then IDLE; any entry to IDLE clears baseline_valid.
REQ-016 FIFO full at push -> entry dropped, overflow set (sticky); push and pop in same cycle while full -> both succeed, no overflow.
REQ-017 EVENT read when empty -> returns 0, no pointer change.
REQ-018 irq SHALL equal irq_en AND not_empty, registered.
REQ-019 PERIOD writes take effect at next timer reload only.

Reset
REQ-020 reset SHALL force: state IDLE, m_read 0, CTRL 0, PERIOD 0, FIFO empty, overflow 0, baseline_valid 0, s_readdata 0, irq 0.
REQ-021 reset asserted mid-READ SHALL drop m_read next edge without waiting on m_waitrequest.

Verification
REQ-022 PERIOD=3, enable=1, input constant 0x5A, waitrequest=0 -> m_read pulses every 5 cycles, STATUS count stays 0, irq 0.
REQ-023 Baseline 0x5A, input changes to 0xA5, irq_en=1 -> after next poll EVENT=0x5AA5, irq=1 one cycle after push; EVENT read -> irq 0.
REQ-024 m_waitrequest held 3 cycles -> m_read stays high 4 cycles, sample taken on last, single event.
REQ-025 Five distinct changes, no reads, DEPTH=4 -> count=4, overflow=1, EVENT reads return first four in order; STATUS write clears overflow.
REQ-026 FIFO full, EVENT read coincident with CMP push -> count stays 4, overflow 0.
REQ-027 enable cleared during READ, then reset pulsed -> transaction completes/aborts per REQ-015/021; all registers at REQ-020 values.
